// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic conflict monitor:
//   - aspect encodings on the signal-head buses ({red, yellow, green})
//   - fault code constants reported on fault_code
//   - approach index constants reported on fault_dir
//   - monitor FSM state enum
//   - small helpers for aspect classification and approach selection
// -----------------------------------------------------------------------------
package traffic_pkg;

  localparam logic [2:0] ASP_RED = 3'b100;
  localparam logic [2:0] ASP_YEL = 3'b010;
  localparam logic [2:0] ASP_GRN = 3'b001;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_INVALID  = 3'd2;
  localparam logic [2:0] FC_PED      = 3'd3;
  localparam logic [2:0] FC_YELLOW   = 3'd4;
  localparam logic [2:0] FC_WDOG     = 3'd5;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_e;

  // Yellow or green lit counts as "non-red"; malformed codes with a yellow or
  // green bit set are treated as showing that colour for conflict purposes.
  function automatic logic is_non_red(input logic [2:0] asp);
    return asp[1] | asp[0];
  endfunction

  // Lowest-numbered approach with its flag set (N first, W last).
  function automatic logic [1:0] first_dir(input logic [3:0] flags);
    if (flags[0])      return DIR_N;
    else if (flags[1]) return DIR_S;
    else if (flags[2]) return DIR_E;
    else if (flags[3]) return DIR_W;
    else               return DIR_N;
  endfunction

endpackage

// File: rtl/aspect_tracker.sv
// -----------------------------------------------------------------------------
// aspect_tracker
// Per-approach history for one signal head. Remembers the aspect seen on the
// previous clk cycle and times the yellow phase in ticks.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            re-sync: load current aspect as history, drop yellow timing
//   run            monitor is in RUN; a green->yellow edge only yields a
//                  trusted yellow count when seen while running
//   tick           1 Hz enable
//   aspect[2:0]    current aspect {red, yellow, green}
//   changed        aspect differs from the previous cycle
//   invalid        aspect is not one-hot (includes 000)
//   short_yellow   pulse: yellow->red with too few ticks (trusted count only),
//                  or green->red with no yellow at all
// -----------------------------------------------------------------------------
module aspect_tracker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       run,
  input  logic       tick,
  input  logic [2:0] aspect,
  output logic       changed,
  output logic       invalid,
  output logic       short_yellow
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MIN_YELLOW);

  logic [2:0]    prev_q, prev_d;
  logic [YW-1:0] ycnt_q, ycnt_d;
  logic          valid_q, valid_d;

  always_comb begin
    prev_d       = aspect;
    ycnt_d       = ycnt_q;
    valid_d      = valid_q;
    changed      = (aspect != prev_q);
    invalid      = !$onehot(aspect);
    short_yellow = 1'b0;

    if (clr) begin
      ycnt_d  = '0;
      valid_d = 1'b0;
    end else if (prev_q == ASP_GRN && aspect == ASP_YEL) begin
      ycnt_d  = '0;
      valid_d = run;
    end else if (aspect == ASP_YEL) begin
      if (tick && ycnt_q != Y_MAX) ycnt_d = ycnt_q + YW'(1);
    end else begin
      // Leaving yellow (or never in it): the count no longer describes a phase.
      valid_d = 1'b0;
    end

    if (prev_q == ASP_YEL && aspect == ASP_RED && valid_q && ycnt_q < Y_MAX)
      short_yellow = 1'b1;
    if (prev_q == ASP_GRN && aspect == ASP_RED)
      short_yellow = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= ASP_RED;
      ycnt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      ycnt_q  <= ycnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor
// Independent safety monitor watching the four signal heads and the ped walk
// indication of a 4-way intersection. On an unsafe or illegal sequence it
// latches a coded fault and requests flash-red from the cabinet output stage.
//
// Optional feature: define TRAFFIC_MON_PED_EN to compile in the pedestrian
// check (code 3). Without it ped_walk is ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tick                1 Hz enable shared with the controller
//   light_north/south/east/west[2:0]  aspects {red, yellow, green}
//   ped_walk            pedestrian walk indication
//   fault_clear         operator clear (level)
//   fault               fault latched (FSM in FAULT)
//   fault_code[2:0]     0 none, 1 conflict, 2 invalid, 3 ped, 4 yellow, 5 wdog
//   fault_dir[1:0]      approach for codes 2 and 4, else 0
//   flash_red           toggles on each tick while faulted
//   armed               FSM in RUN
// FSM state is fully visible as {fault, armed}: 00 ARM, 01 RUN, 10 FAULT.
// -----------------------------------------------------------------------------
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3,
  parameter int WDOG_TICKS = 30,
  parameter int FILTER_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [2:0] light_north,
  input  logic [2:0] light_south,
  input  logic [2:0] light_east,
  input  logic [2:0] light_west,
  input  logic       ped_walk,
  input  logic       fault_clear,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir,
  output logic       flash_red,
  output logic       armed
);

  localparam int FW = $clog2(FILTER_CYC + 1);
  localparam int WW = $clog2(WDOG_TICKS + 1);
  localparam logic [FW-1:0] F_MAX  = FW'(FILTER_CYC);
  // A condition already held for FILTER_CYC-1 cycles qualifies on this edge.
  localparam logic [FW-1:0] F_QUAL = FW'(FILTER_CYC - 1);
  localparam logic [WW-1:0] W_MAX  = WW'(WDOG_TICKS);

  mon_state_e    state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [1:0]    dir_q, dir_d;
  logic          flash_q, flash_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [FW-1:0] arm_q, arm_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          seen_q, seen_d;

  logic [2:0] asp [4];
  logic [3:0] chg_v, inv_v, sy_v, nonred_v;
  logic       trk_clr, run_now;

  logic conflict, inv_any, ped_bad, static_bad, arm_bad, filt_ok, wdog_hit;

  assign asp[0]  = light_north;
  assign asp[1]  = light_south;
  assign asp[2]  = light_east;
  assign asp[3]  = light_west;
  assign run_now = (state_q == ST_RUN);

  for (genvar g = 0; g < 4; g++) begin : g_trk
    aspect_tracker #(
      .MIN_YELLOW (MIN_YELLOW)
    ) u_trk (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr          (trk_clr),
      .run          (run_now),
      .tick         (tick),
      .aspect       (asp[g]),
      .changed      (chg_v[g]),
      .invalid      (inv_v[g]),
      .short_yellow (sy_v[g])
    );
    assign nonred_v[g] = is_non_red(asp[g]);
  end

`ifdef TRAFFIC_MON_PED_EN
  assign ped_bad = ped_walk & (|nonred_v);
`else
  logic unused_ped;
  assign unused_ped = ped_walk;
  assign ped_bad    = 1'b0;
`endif

  // Static checks and shared filter.
  always_comb begin
    conflict   = (nonred_v[0] | nonred_v[1]) & (nonred_v[2] | nonred_v[3]);
    inv_any    = |inv_v;
    static_bad = conflict | inv_any | ped_bad;
    arm_bad    = conflict | inv_any;
    filt_ok    = static_bad && (filt_q >= F_QUAL);
    if (!static_bad)        filt_d = '0;
    else if (filt_q != F_MAX) filt_d = filt_q + FW'(1);
    else                    filt_d = filt_q;
  end

  // Watchdog: a tick counts only if no aspect changed since the previous tick.
  // seen_q remembers a change that happened between ticks.
  always_comb begin
    wdog_d = wdog_q;
    seen_d = seen_q;
    if (!run_now) begin
      wdog_d = '0;
      seen_d = 1'b0;
    end else if (|chg_v) begin
      wdog_d = '0;
      seen_d = !tick;
    end else if (tick) begin
      if (!seen_q && wdog_q != W_MAX) wdog_d = wdog_q + WW'(1);
      seen_d = 1'b0;
    end
    wdog_hit = (wdog_d == W_MAX);
  end

  // FSM next state and latched outputs.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dir_d   = dir_q;
    flash_d = flash_q;
    arm_d   = '0;
    trk_clr = 1'b0;

    case (state_q)
      ST_ARM: begin
        if (!arm_bad) arm_d = (arm_q != F_MAX) ? arm_q + FW'(1) : arm_q;
        if (!arm_bad && arm_q >= F_QUAL) begin
          state_d = ST_RUN;
          trk_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (filt_ok) begin
          state_d = ST_FAULT;
          dir_d   = DIR_N;
          if (conflict) code_d = FC_CONFLICT;
          else if (inv_any) begin
            code_d = FC_INVALID;
            dir_d  = first_dir(inv_v);
          end else code_d = FC_PED;
        end else if (|sy_v) begin
          state_d = ST_FAULT;
          code_d  = FC_YELLOW;
          dir_d   = first_dir(sy_v);
        end else if (wdog_hit) begin
          state_d = ST_FAULT;
          code_d  = FC_WDOG;
          dir_d   = DIR_N;
        end
        flash_d = 1'b0;
      end
      ST_FAULT: begin
        if (tick) flash_d = !flash_q;
        if (fault_clear && !static_bad) begin
          state_d = ST_ARM;
          code_d  = FC_NONE;
          dir_d   = DIR_N;
          flash_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_ARM;
        code_d  = FC_NONE;
        dir_d   = DIR_N;
        flash_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARM;
      code_q  <= FC_NONE;
      dir_q   <= DIR_N;
      flash_q <= 1'b0;
      filt_q  <= '0;
      arm_q   <= '0;
      wdog_q  <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      flash_q <= flash_d;
      filt_q  <= filt_d;
      arm_q   <= arm_d;
      wdog_q  <= wdog_d;
      seen_q  <= seen_d;
    end
  end

  assign fault      = (state_q == ST_FAULT);
  assign armed      = run_now;
  assign fault_code = code_q;
  assign fault_dir  = dir_q;
  assign flash_red  = flash_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_conflict_monitor
// Directed scenarios for the conflict monitor. Each driven cycle pushes the
// expected output vector {flash_red, armed, fault, fault_code, fault_dir}
// onto exp_q; after the clock edge the vector is popped and compared.
// Inputs change 1 ns after the rising edge; outputs are sampled there too,
// before the next stimulus is applied.
// -----------------------------------------------------------------------------
module tb_traffic_conflict_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [7:0] V_ARM = 8'b0000_0000;
  localparam logic [7:0] V_RUN = 8'b0100_0000;

  logic       clk = 1'b0;
  logic       rst_n, tick, ped_walk, fault_clear;
  logic [2:0] light_north, light_south, light_east, light_west;
  logic       fault, flash_red, armed;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  traffic_conflict_monitor #(
    .MIN_YELLOW (3),
    .WDOG_TICKS (30),
    .FILTER_CYC (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .light_north (light_north),
    .light_south (light_south),
    .light_east  (light_east),
    .light_west  (light_west),
    .ped_walk    (ped_walk),
    .fault_clear (fault_clear),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_dir   (fault_dir),
    .flash_red   (flash_red),
    .armed       (armed)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [7:0] fv(input logic fl, input logic [2:0] code,
                                    input logic [1:0] dir);
    return {fl, 1'b0, 1'b1, code, dir};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {flash_red, armed, fault, fault_code, fault_dir};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got {fl,arm,flt,code,dir}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_lights(input logic [2:0] n, input logic [2:0] s,
                            input logic [2:0] e, input logic [2:0] w);
    light_north = n;
    light_south = s;
    light_east  = e;
    light_west  = w;
  endtask

  // One clock cycle with the current inputs; scoreboard push then pop/compare.
  task automatic run_cycle(input logic t, input logic [7:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    check(tag_q.pop_front(), dut_vec(), exp_q.pop_front());
  endtask

  // One 1 Hz period: three idle cycles then the tick cycle.
  task automatic tick_period(input logic [7:0] e, input string tag);
    repeat (3) run_cycle(1'b0, e, tag);
    run_cycle(1'b1, e, tag);
  endtask

  // Controller phase: aspects change right after a tick, like the controller.
  task automatic phase(input logic [2:0] ns, input logic [2:0] ew, input int nt);
    set_lights(ns, ns, ew, ew);
    repeat (nt) tick_period(V_RUN, "ctrl_cycle");
  endtask

  // Clean inputs plus fault_clear: FAULT -> ARM, then two clean cycles to RUN.
  task automatic rearm();
    set_lights(R, R, R, R);
    ped_walk    = 1'b0;
    fault_clear = 1'b1;
    run_cycle(1'b0, V_ARM, "clear_to_arm");
    fault_clear = 1'b0;
    run_cycle(1'b0, V_ARM, "arm_qual");
    run_cycle(1'b0, V_RUN, "arm_run");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic f;
    rst_n = 1'b0; tick = 1'b0; ped_walk = 1'b0; fault_clear = 1'b0;
    set_lights(R, R, R, R);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), V_ARM);
    rst_n = 1'b1;
    run_cycle(1'b0, V_ARM, "arm_first_clean");
    run_cycle(1'b0, V_RUN, "arm_to_run");

    // Legal controller cycle: 80 ticks, no fault.
    for (int rep = 0; rep < 5; rep++) begin
      phase(G, R, 5);
      phase(Y, R, 3);
      phase(R, G, 5);
      phase(R, Y, 3);
    end
    set_lights(R, R, R, R);
    run_cycle(1'b0, V_RUN, "ctrl_end_red");

    // Conflict N+E green for 2 cycles.
    set_lights(G, R, G, R);
    run_cycle(1'b0, V_RUN, "conflict_c1");
    run_cycle(1'b0, fv(1'b0, 3'd1, 2'd0), "conflict_c2");
    rearm();

    // Conflict for only 1 cycle (yellow, no trusted count): no fault.
    set_lights(Y, R, Y, R);
    run_cycle(1'b0, V_RUN, "conflict_short");
    set_lights(R, R, R, R);
    run_cycle(1'b0, V_RUN, "conflict_short_gone");
    run_cycle(1'b0, V_RUN, "conflict_short_gone2");

    // West 3'b110: invalid, dir W; dirty clear ignored; clean clear re-arms.
    set_lights(R, R, R, 3'b110);
    run_cycle(1'b0, V_RUN, "invalid_c1");
    run_cycle(1'b0, fv(1'b0, 3'd2, 2'd3), "invalid_w");
    fault_clear = 1'b1;
    run_cycle(1'b0, fv(1'b0, 3'd2, 2'd3), "dirty_clear");
    rearm();

    // North and West both 000: lowest approach reported.
    set_lights(3'b000, R, R, 3'b000);
    run_cycle(1'b0, V_RUN, "invalid2_c1");
    run_cycle(1'b0, fv(1'b0, 3'd2, 2'd0), "invalid_lowest_dir");
    rearm();

    // Conflict and invalid together: conflict has priority.
    set_lights(G, R, 3'b011, R);
    run_cycle(1'b0, V_RUN, "prio_c1");
    run_cycle(1'b0, fv(1'b0, 3'd1, 2'd0), "prio_conflict");
    rearm();

    // South yellow for only 2 ticks then red.
    set_lights(R, G, R, R);
    tick_period(V_RUN, "south_green");
    set_lights(R, Y, R, R);
    tick_period(V_RUN, "south_yel_t1");
    tick_period(V_RUN, "south_yel_t2");
    set_lights(R, R, R, R);
    run_cycle(1'b0, fv(1'b0, 3'd4, 2'd1), "short_yellow_s");
    rearm();

    // East green straight to red.
    set_lights(R, R, G, R);
    tick_period(V_RUN, "east_green");
    set_lights(R, R, R, R);
    run_cycle(1'b0, fv(1'b0, 3'd4, 2'd2), "green_to_red_e");
    rearm();

    // Frozen aspects from RUN entry: fault on the 30th tick.
    repeat (29) tick_period(V_RUN, "wdog_count");
    repeat (3) run_cycle(1'b0, V_RUN, "wdog_pre");
    run_cycle(1'b1, fv(1'b0, 3'd5, 2'd0), "wdog_fault");
    f = 1'b0;
    repeat (3) begin
      repeat (3) run_cycle(1'b0, fv(f, 3'd5, 2'd0), "flash_hold");
      run_cycle(1'b1, fv(!f, 3'd5, 2'd0), "flash_toggle");
      f = !f;
    end

    // Asynchronous reset in the middle of a fault.
    #2 rst_n = 1'b0;
    #1 check("reset_mid_fault", dut_vec(), V_ARM);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_cycle(1'b0, V_ARM, "post_reset_arm");
    run_cycle(1'b0, V_RUN, "post_reset_run");

    // Ped walk with East green.
    set_lights(R, R, G, R);
    ped_walk = 1'b1;
`ifdef TRAFFIC_MON_PED_EN
    run_cycle(1'b0, V_RUN, "ped_c1");
    run_cycle(1'b0, fv(1'b0, 3'd3, 2'd0), "ped_fault");
`else
    run_cycle(1'b0, V_RUN, "ped_ignored_c1");
    run_cycle(1'b0, V_RUN, "ped_ignored_c2");
    run_cycle(1'b0, V_RUN, "ped_ignored_c3");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
# traffic_conflict_monitor

- Independent safety monitor on the signal-head side of `traffic_light_4way`; reads the four 3-bit aspect buses and `ped_walk`.
- Detects unsafe or illegal light sequences: conflicting greens, invalid aspects, short or skipped yellow, and stuck controller.
- Latches a coded fault and drives a flash-red override request to the cabinet output stage.
- Runs on the same clock and 1 Hz tick enable as the controller.

## Interface
- `MIN_YELLOW`, 3: minimum yellow duration, in ticks.
- `WDOG_TICKS`, 30: ticks with no aspect change before a stuck fault.
- `FILTER_CYC`, 2: consecutive clk cycles a static violation must persist before it faults.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick` input 1: one-cycle 1 Hz enable, same as the controller's `clk_enable`.
- `light_north`, `light_south`, `light_east`, `light_west` input 3 each: aspect, {red, yellow, green}; bit2 = red.
- `ped_walk` input 1: pedestrian walk indication.
- `fault_clear` input 1: operator clear request; level sampled.
- `fault` output 1: fault latched.
- `fault_code` output 3: 0 none, 1 conflict, 2 invalid, 3 ped, 4 yellow, 5 watchdog.
- `fault_dir` output 2: approach for codes 2/4 (0 N, 1 S, 2 E, 3 W), else 0.
- `flash_red` output 1: toggles on each tick while faulted.
- `armed` output 1: monitor in RUN.

## Operation
- FSM states: ARM, RUN, FAULT. All transitions occur on the `clk` edge.
- ARM → RUN once no conflict or invalid condition has been present for `FILTER_CYC` consecutive cycles. Per-approach trackers are cleared on entry to RUN.
- RUN → FAULT on any qualified violation. The code and dir are latched in the same edge.
- FAULT → ARM when `fault_clear` = 1 and the static checks are currently clean. Otherwise the monitor stays in FAULT; code and dir hold.
- Conflict (code 1): N or S is non-red (yellow or green) while E or W is non-red. Filtered.
- Invalid (code 2): any aspect not one-hot, including 000. Filtered. Lowest-numbered approach wins for `fault_dir`.
- Ped (code 3): `ped_walk` = 1 while any approach is non-red. Filtered.
- Yellow (code 4): an approach goes yellow→red with its yellow count < `MIN_YELLOW`, or goes green→red directly. Not filtered.
  - The yellow count is only valid if the green→yellow edge was seen in RUN. Otherwise the check is skipped for that phase.
- Watchdog (code 5): counter increments on each `tick` with no aspect change since the previous tick. It resets on any aspect change. Fault when the count = `WDOG_TICKS`.
- Priority when several violations qualify in the same cycle: 1 > 2 > 3 > 4 > 5.
- Yellow counter per approach: clears on green→yellow, increments on tick while yellow, saturates at `MIN_YELLOW`. Width is $clog2(MIN_YELLOW+1). The watchdog counter saturates at `WDOG_TICKS`.
- Filter counter is shared across static checks, saturating. It clears in any cycle where all static checks are clean.

## Timing
- Reset values: ARM state, `fault` 0, `fault_code` 0, `fault_dir` 0, `flash_red` 0, `armed` 0; all counters 0.
- Static violation first present at edge k → `fault` = 1 after edge k+`FILTER_CYC`-1.
- A violation lasting `FILTER_CYC`-1 cycles does not fault.
- Yellow fault: `fault` = 1 at the edge that samples the red aspect, i.e. 1-cycle latency.
- `flash_red` goes 0 on FAULT entry, then toggles on each tick. It is forced to 0 on leaving FAULT.
- `fault_clear` with dirty inputs has no effect. With clean inputs, `fault` drops the next edge and ARM re-qualifies.
- `rst_n` low mid-fault clears everything immediately (asynchronous).
- A tick and a violation in the same cycle: the violation wins; the watchdog does not also report.

## Configuration
- `TRAFFIC_MON_PED_EN` defined: ped check (code 3) compiled in.
- Undefined: `ped_walk` is ignored and code 3 is never produced. All other behaviour is unchanged.

## Structure
- `traffic_pkg` holds: aspect encodings (RED 3'b100, YEL 3'b010, GRN 3'b001), the fault code constants, the FSM state enum, and the approach index constants.
- Sub-module `aspect_tracker`, instantiated 4×. It holds the previous aspect, yellow counter and valid flag, and outputs `changed`, `invalid` and `short_yellow` pulses.

## Test plan
- Controller cycle N/S G(5)→Y(3)→R, E/W likewise → `armed` 1, `fault` stays 0 for 80 ticks.
- North and East both green for 2 cycles → `fault_code` 1 two cycles later; for 1 cycle → no fault.
- West aspect 3'b110 for 2 cycles → code 2, `fault_dir` 3; then `fault_clear` with clean inputs → `fault` 0, ARM, then RUN.
- South yellow 2 ticks then red → code 4, dir 1. Green→red directly → code 4.
- Aspects frozen for 30 ticks → code 5; `flash_red` toggles each subsequent tick.
- `ped_walk` 1 with East green → code 3 with the macro defined, no fault without it. Reset asserted mid-fault → all outputs 0.
